// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int PC_INC_DEF = 4;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_e;

  typedef struct packed {
    logic [XLEN_DEF-1:0] instr;
    logic [XLEN_DEF-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; holds PCs or {instr, pc} fetch entries.
module fetch_queue #(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  // Storage is cleared on reset so the head reads as zero before any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues word fetches, tracks in-flight responses, queues them for decode.
// Optional FETCH_MISALIGN_CHK_EN: flag misaligned redirects and force them word aligned.
module fetch_ctrl import fetch_pkg::*; #(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              PC_INC   = PC_INC_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
  parameter int              DEPTH    = 2
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_addr_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            fetch_err_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [1:0] S_BOOT  = 2'(BOOT);
  localparam logic [1:0] S_RUN   = 2'(RUN);
  localparam logic [1:0] S_FLUSH = 2'(FLUSH);

  logic [1:0]      state;
  logic [XLEN-1:0] fetch_pc, tgt, pcq_head;
  logic [CW-1:0]   outstanding, iq_count, drop_cnt, out_next, drop_next;
  logic [CW:0]     in_use;
  logic            gnt, redir, dropping, iq_push, iq_pop, iq_empty;
  logic            pcq_empty, pcq_full, iq_full;
  fetch_entry_t    iq_din, iq_dout;

  // In-flight plus queued never exceeds DEPTH, so every response has a slot.
  assign in_use     = {1'b0, outstanding} + {1'b0, iq_count};
  assign mem_req_o  = (state == S_RUN || (state == S_FLUSH && drop_cnt != DEPTH_C)) &&
                      (in_use < {1'b0, DEPTH_C});
  assign mem_addr_o = fetch_pc;
  assign gnt        = mem_req_o & mem_gnt_i;
  assign redir      = redirect_valid_i && (state != S_BOOT);
  assign out_next   = outstanding + CW'(gnt) - CW'(mem_rvalid_i);
  assign dropping   = mem_rvalid_i && (drop_cnt != '0);
  assign iq_push    = mem_rvalid_i && !dropping;
  assign iq_pop     = instr_valid_o & instr_ready_i;
  assign drop_next  = redir ? out_next : drop_cnt - CW'(dropping);

  assign iq_din.instr  = mem_rdata_i;
  assign iq_din.pc     = pcq_head;
  assign instr_valid_o = ~iq_empty;
  assign instr_o       = iq_dout.instr;
  assign pc_o          = iq_dout.pc;

`ifdef FETCH_MISALIGN_CHK_EN
  logic err_q;
  assign tgt         = {redirect_addr_i[XLEN-1:2], 2'b00};
  assign fetch_err_o = err_q;
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i)                                  err_q <= 1'b0;
    else if (redir && redirect_addr_i[1:0] != 2'b00) err_q <= 1'b1;
  end
`else
  assign tgt         = redirect_addr_i;
  assign fetch_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state    <= S_BOOT;
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_next;
      if (redir)    fetch_pc <= tgt;
      else if (gnt) fetch_pc <= fetch_pc + XLEN'(PC_INC);
      if (state == S_BOOT)                       state <= S_RUN;
      else if (redir)                            state <= (out_next != '0) ? S_FLUSH : S_RUN;
      else if (state == S_FLUSH && drop_next == '0) state <= S_RUN;
    end
  end

  // PC queue depth equals the number of requests awaiting a response.
  fetch_queue #(.W(XLEN), .DEPTH(DEPTH)) u_pcq (
    .clk(clk_i), .rst_n(resetn_i),
    .push(gnt), .pop(mem_rvalid_i), .flush(1'b0),
    .din(fetch_pc), .dout(pcq_head), .count(outstanding),
    .empty(pcq_empty), .full(pcq_full)
  );

  fetch_queue #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_iq (
    .clk(clk_i), .rst_n(resetn_i),
    .push(iq_push), .pop(iq_pop), .flush(redir),
    .din(iq_din), .dout(iq_dout), .count(iq_count),
    .empty(iq_empty), .full(iq_full)
  );

  a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (!resetn_i)
    mem_rvalid_i |-> !pcq_empty);
  a_pcq_no_overflow: assert property (@(posedge clk_i) disable iff (!resetn_i)
    gnt |-> !pcq_full);
  a_iq_no_overflow: assert property (@(posedge clk_i) disable iff (!resetn_i)
    (iq_push && !redir) |-> (!iq_full || iq_pop));
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a fixed-latency memory model and delivery scoreboard.
module tb_fetch_ctrl;
  localparam int DEPTH = 2;

  logic        clk = 1'b0, resetn = 1'b1;
  logic        mem_req, mem_gnt, mem_rvalid, redir_v, instr_valid, instr_ready, fetch_err;
  logic [31:0] mem_addr, mem_rdata, redir_a, instr, pc;

  fetch_ctrl #(.XLEN(32), .PC_INC(4), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .resetn_i(resetn),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .redirect_valid_i(redir_v), .redirect_addr_i(redir_a),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .pc_o(pc), .fetch_err_o(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; int due;} rsp_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
  rsp_t rsp_q[$];
  exp_t exp_q[$];

  int vec = 0, miss = 0, cyc = 0, gnt_cnt = 0, first_gnt = -1, first_vld = -1, mark;
  logic gnt_en = 1'b0, rdy = 1'b0, rsp_hold = 1'b0, watch = 1'b0, stale_seen = 1'b0;
  logic [31:0] exp_addr = 32'h0, last_gnt_addr = 32'h0, first_pc = 32'hDEAD_BEEF;
  logic [31:0] stale_a = 32'hFFFF_FFF1, stale_b = 32'hFFFF_FFF1;
  logic [31:0] exp_err, exp_maddr;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One cycle: drive at negedge, observe mid-cycle, update model, advance to next negedge.
  task automatic step(input logic r_v = 1'b0, input logic [31:0] r_a = 32'h0);
    logic g;
    exp_t e;
    g = gnt_en;
    mem_gnt = g; instr_ready = rdy; redir_v = r_v; redir_a = r_a;
    if (!rsp_hold && rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd_of(rsp_q[0].addr);
      void'(rsp_q.pop_front());
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end
    #1;
    if (instr_valid && first_vld < 0) first_vld = cyc;
    if (instr_valid && rdy) begin
      if (exp_q.size() == 0) chk("spurious_valid", 32'(instr_valid), 32'h0);
      else begin
        e = exp_q.pop_front();
        chk("pc", pc, e.pc);
        chk("instr", instr, e.instr);
      end
      if (watch) begin first_pc = pc; watch = 1'b0; end
      if (pc == stale_a || pc == stale_b) stale_seen = 1'b1;
    end
    if (mem_req && g) begin
      chk("addr", mem_addr, exp_addr);
      rsp_q.push_back('{mem_addr, cyc + 1});
      last_gnt_addr = mem_addr;
      gnt_cnt++;
      if (first_gnt < 0) first_gnt = cyc;
      if (!r_v) exp_q.push_back('{mem_addr, rd_of(mem_addr)});
      exp_addr = exp_addr + 32'd4;
    end
    if (r_v) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_CHK_EN
      exp_addr = {r_a[31:2], 2'b00};
`else
      exp_addr = r_a;
`endif
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    gnt_en = 1'b0;
    rdy    = 1'b1;
    repeat (6) step();
    chk("drain", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0; redir_v = 0; redir_a = 0; instr_ready = 0;
    #2 resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_err", 32'(fetch_err), 32'h0);
    resetn = 1'b1;
    chk("boot_req", 32'(mem_req), 32'h0);

    // Sequential fetch, always granted, decode always ready.
    gnt_en = 1'b1; rdy = 1'b1; watch = 1'b1;
    repeat (8) step();
    chk("first_gnt_cycle", 32'(first_gnt), 32'd1);
    chk("first_latency", 32'(first_vld - first_gnt), 32'd2);
    chk("first_pc", first_pc, 32'h0);

    // Decode stalled: queue fills and issue stops without losing responses.
    rdy = 1'b0;
    repeat (10) step();
    chk("stall_req", 32'(mem_req), 32'h0);
    chk("stall_valid", 32'(instr_valid), 32'h1);
    rdy = 1'b1;
    repeat (8) step();
    drain();

    // Two outstanding at 0x10/0x14, redirect to 0x100 drops both.
    step(1'b1, 32'h10);
    rsp_hold = 1'b1; gnt_en = 1'b1;
    repeat (4) step();
    chk("full_req", 32'(mem_req), 32'h0);
    chk("last_gnt_0x14", last_gnt_addr, 32'h14);
    stale_a = 32'h10; stale_b = 32'h14; stale_seen = 1'b0;
    step(1'b1, 32'h100);
    first_pc = 32'hDEAD_BEEF; watch = 1'b1; rsp_hold = 1'b0;
    repeat (8) step();
    chk("redir_first_pc", first_pc, 32'h100);
    chk("redir_no_stale", 32'(stale_seen), 32'h0);
    drain();

    // Redirect coincident with grant of 0x20, then back-to-back redirect to 0x200.
    step(1'b1, 32'h20);
    for (int i = 0; i < 10 && !(mem_req && mem_addr == 32'h20); i++) step();
    chk("req_at_0x20", 32'(mem_req && mem_addr == 32'h20), 32'h1);
    gnt_en = 1'b1;
    step(1'b1, 32'h80);
    step(1'b1, 32'h200);
    stale_a = 32'h20; stale_b = 32'h80; stale_seen = 1'b0;
    first_pc = 32'hDEAD_BEEF; watch = 1'b1;
    repeat (10) step();
    chk("b2b_first_pc", first_pc, 32'h200);
    chk("b2b_no_stale", 32'(stale_seen), 32'h0);
    drain();

    // Address wrap past the top of the address space.
    step(1'b1, 32'hFFFF_FFFC);
    gnt_en = 1'b1;
    mark = gnt_cnt;
    for (int i = 0; i < 12 && gnt_cnt < mark + 2; i++) step();
    chk("wrap_gnt_count", 32'(gnt_cnt - mark), 32'd2);
    chk("wrap_addr", last_gnt_addr, 32'h0);
    drain();

    // Misaligned redirect.
`ifdef FETCH_MISALIGN_CHK_EN
    exp_err = 32'h1; exp_maddr = 32'h100;
`else
    exp_err = 32'h0; exp_maddr = 32'h102;
`endif
    step(1'b1, 32'h102);
    for (int i = 0; i < 10 && !mem_req; i++) step();
    chk("misalign_err", 32'(fetch_err), exp_err);
    chk("misalign_addr", mem_addr, exp_maddr);
    step(1'b1, 32'h200);
    chk("err_sticky", 32'(fetch_err), exp_err);
    gnt_en = 1'b1;
    repeat (6) step();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end
endmodule
